fifo_wptr_full: RTL and testbench



---
 rtl/fifo_ptr_pkg.sv | 32 +++
 rtl/fifo_wptr_full.sv | 74 +++++++
 tb/tb_fifo_wptr_full.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_ptr_pkg.sv
// Gray-pointer helpers shared by the write-side full and read-side empty generators.
// Functions work on a zero-extended ptr_t; callers cast results back to their pointer width.
package fifo_ptr_pkg;

   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   function automatic ptr_t f_bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; the zero extension above the real width is harmless.
   function automatic ptr_t f_gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Value the write Gray pointer takes when it is exactly one lap ahead of the read pointer.
   function automatic ptr_t f_full_cmp(input ptr_t g, input int w);
      ptr_t r;
      r = g;
      r[w-1] = ~g[w-1];
      r[w-2] = ~g[w-2];
      return r;
   endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full, level and overflow generator for a dual-clock Gray-pointer FIFO.
// Define FIFO_WPTR_LEVEL_EN to build wlevel / walmost_full; otherwise both are tied to 0.
module fifo_wptr_full
   import fifo_ptr_pkg::*;
#(
   parameter int AW        = 4,
   parameter int AF_MARGIN = 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          winc,
   input  logic [AW:0]   rptr_gray_sync,
   input  logic          ovf_clr,
   output logic [AW-1:0] waddr,
   output logic [AW:0]   wptr_gray,
   output logic          wfull,
   output logic          walmost_full,
   output logic [AW:0]   wlevel,
   output logic          overflow
);

   localparam int PW = AW + 1;

   logic          wacc;
   logic [AW:0]   wbin;
   logic [AW:0]   wbin_next;
   logic [AW:0]   wgray_next;
   logic [AW:0]   rptr_full;

   assign wacc       = winc & ~wfull;
   assign wbin_next  = wbin + PW'(wacc);
   assign wgray_next = PW'(f_bin2gray(ptr_t'(wbin_next)));
   assign rptr_full  = PW'(f_full_cmp(ptr_t'(rptr_gray_sync), PW));
   assign waddr      = wbin[AW-1:0];

   // Full uses the next pointer so it asserts on the edge that fills the last slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin      <= '0;
         wptr_gray <= '0;
         wfull     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         wbin      <= wbin_next;
         wptr_gray <= wgray_next;
         wfull     <= (wgray_next == rptr_full);
         overflow  <= (winc & wfull) | (overflow & ~ovf_clr);
      end
   end

`ifdef FIFO_WPTR_LEVEL_EN
   localparam logic [AW:0] AF_TH = PW'((1 << AW) - AF_MARGIN);

   logic [AW:0] rbin;
   logic [AW:0] wlevel_next;

   assign rbin        = PW'(f_gray2bin(ptr_t'(rptr_gray_sync)));
   assign wlevel_next = wbin_next - rbin;

   always_ff @(posedge clk) begin
      if (rst) begin
         wlevel       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wlevel       <= wlevel_next;
         walmost_full <= (wlevel_next >= AF_TH);
      end
   end
`else
   assign wlevel       = '0;
   assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed scoreboard bench for fifo_wptr_full with AW=2, AF_MARGIN=1.
module tb_fifo_wptr_full;

   localparam int AW = 2;
   localparam int AF_MARGIN = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          winc;
   logic [AW:0]   rptr_gray_sync;
   logic          ovf_clr;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr_gray;
   logic          wfull;
   logic          walmost_full;
   logic [AW:0]   wlevel;
   logic          overflow;

   typedef struct {
      logic [2:0] gray;
      logic [1:0] addr;
      logic       full;
      logic       af;
      logic [2:0] lvl;
      logic       ovf;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   fifo_wptr_full #(.AW(AW), .AF_MARGIN(AF_MARGIN)) dut (
      .clk(clk), .rst(rst), .winc(winc), .rptr_gray_sync(rptr_gray_sync),
      .ovf_clr(ovf_clr), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
      .walmost_full(walmost_full), .wlevel(wlevel), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s step %0d: got %0h want %0h", name, step, act, req);
      end
   endtask

   // Monitor: one expectation per clock, checked just after the edge it describes.
   int step_no = 0;
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         step_no++;
         chk("wptr_gray", step_no, 32'(wptr_gray), 32'(e.gray));
         chk("waddr", step_no, 32'(waddr), 32'(e.addr));
         chk("wfull", step_no, 32'(wfull), 32'(e.full));
         chk("walmost_full", step_no, 32'(walmost_full), 32'(e.af));
         chk("wlevel", step_no, 32'(wlevel), 32'(e.lvl));
         chk("overflow", step_no, 32'(overflow), 32'(e.ovf));
      end
   end

   task automatic vec(input logic r, input logic w, input logic [2:0] rg, input logic clr,
                      input logic [2:0] g, input logic [1:0] a, input logic f,
                      input logic af, input logic [2:0] l, input logic o);
      exp_t e;
      @(negedge clk);
      rst = r; winc = w; rptr_gray_sync = rg; ovf_clr = clr;
      e.gray = g; e.addr = a; e.full = f; e.ovf = o;
`ifdef FIFO_WPTR_LEVEL_EN
      e.af = af; e.lvl = l;
`else
      e.af = 1'b0; e.lvl = 3'd0;
`endif
      q.push_back(e);
   endtask

   initial begin
      rst = 1'b1; winc = 1'b0; rptr_gray_sync = '0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      //   rst w  rptr  clr  gray  addr full af lvl ovf
      vec(1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);   // reset state
      // fill from empty
      vec(0, 1, 3'b000, 0, 3'b001, 1, 0, 0, 1, 0);
      vec(0, 1, 3'b000, 0, 3'b011, 2, 0, 0, 2, 0);
      vec(0, 1, 3'b000, 0, 3'b010, 3, 0, 1, 3, 0);
      vec(0, 1, 3'b000, 0, 3'b110, 0, 1, 1, 4, 0);
      // writes while full are dropped and set overflow
      vec(0, 1, 3'b000, 0, 3'b110, 0, 1, 1, 4, 1);
      vec(0, 1, 3'b000, 0, 3'b110, 0, 1, 1, 4, 1);
      vec(0, 1, 3'b000, 0, 3'b110, 0, 1, 1, 4, 1);
      vec(0, 0, 3'b000, 1, 3'b110, 0, 1, 1, 4, 0);
      vec(0, 1, 3'b000, 1, 3'b110, 0, 1, 1, 4, 1);   // set wins over clear
      // read pointer advances while a write is attempted on full
      vec(0, 1, 3'b001, 0, 3'b110, 0, 0, 1, 3, 1);
      vec(0, 1, 3'b001, 0, 3'b111, 1, 1, 1, 4, 1);
      vec(0, 0, 3'b001, 1, 3'b111, 1, 1, 1, 4, 0);
      // reader tracks writer one cycle behind, pointer wraps
      vec(1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
      vec(0, 1, 3'b000, 0, 3'b001, 1, 0, 0, 1, 0);
      vec(0, 1, 3'b001, 0, 3'b011, 2, 0, 0, 1, 0);
      vec(0, 1, 3'b011, 0, 3'b010, 3, 0, 0, 1, 0);
      vec(0, 1, 3'b010, 0, 3'b110, 0, 0, 0, 1, 0);
      vec(0, 1, 3'b110, 0, 3'b111, 1, 0, 0, 1, 0);
      vec(0, 1, 3'b111, 0, 3'b101, 2, 0, 0, 1, 0);
      vec(0, 1, 3'b101, 0, 3'b100, 3, 0, 0, 1, 0);
      vec(0, 1, 3'b100, 0, 3'b000, 0, 0, 0, 1, 0);
      vec(0, 1, 3'b000, 0, 3'b001, 1, 0, 0, 1, 0);
      vec(0, 1, 3'b001, 0, 3'b011, 2, 0, 0, 1, 0);
      // three writes into empty: almost full but not full
      vec(1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
      vec(0, 1, 3'b000, 0, 3'b001, 1, 0, 0, 1, 0);
      vec(0, 1, 3'b000, 0, 3'b011, 2, 0, 0, 2, 0);
      vec(0, 1, 3'b000, 0, 3'b010, 3, 0, 1, 3, 0);
      // full at wptr_gray=011 with overflow, then reset mid-operation
      vec(1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
      vec(0, 1, 3'b101, 0, 3'b001, 1, 0, 1, 3, 0);
      vec(0, 1, 3'b101, 0, 3'b011, 2, 1, 1, 4, 0);
      vec(0, 1, 3'b101, 0, 3'b011, 2, 1, 1, 4, 1);
      vec(1, 0, 3'b101, 0, 3'b000, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0; winc = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
